// File: rtl/time_entry.sv
// -----------------------------------------------------------------------------
// time_entry
//
// Cook-time entry and countdown for the microwave front panel.
//
// Keypad digits are shifted in from the right to build a BCD MM:SS value.
// A start edge launches a countdown on the 1 Hz tick, and completion is
// flagged to the door/magnetron control and display stages.
//
// Parameters
//   DIGITS    number of BCD digits held (3..6). The lowest two digits are
//             seconds; the remaining DIGITS-2 digits are minutes.
//   SEC_WRAP  seconds value (decimal) loaded when a minute is borrowed.
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   digit[3:0]   in   keypad encoder digit code, 0-9 valid
//   key_valid    in   level, high while any key is held
//   clear        in   synchronous clear/abort, level-sampled
//   start        in   start request, level-sampled (edge-detected here)
//   tick         in   one-cycle 1 Hz strobe
//   time_bcd     out  current time, BCD, most significant digit first
//   entry_count  out  digits entered so far, 0..DIGITS
//   running      out  high while counting down
//   done         out  high once the countdown has reached zero
//
// Build option
//   PAUSE_EN  when defined, a start edge while running pauses the countdown
//             and a further start edge resumes it. When undefined, start
//             edges are ignored while running.
// -----------------------------------------------------------------------------
module time_entry #(
  parameter int DIGITS   = 4,
  parameter int SEC_WRAP = 59
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            digit,
  input  logic                  key_valid,
  input  logic                  clear,
  input  logic                  start,
  input  logic                  tick,
  output logic [4*DIGITS-1:0]   time_bcd,
  output logic [2:0]            entry_count,
  output logic                  running,
  output logic                  done
);

  localparam int W = 4 * DIGITS;

  // Seconds reload value split into its two BCD digits (ones in [3:0]).
  localparam logic [7:0] WRAP_BCD = {4'(SEC_WRAP / 10), 4'(SEC_WRAP % 10)};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
`ifdef PAUSE_EN
    ,
    ST_PAUSED
`endif
  } state_t;

  state_t          state_reg;
  logic [W-1:0]    time_reg;
  logic [2:0]      count_reg;
  logic            running_reg;
  logic            done_reg;
  logic            key_q_reg;
  logic            start_q_reg;

  logic            key_press;
  logic            start_edge;
  logic            digit_ok;
  logic            entry_room;
  logic            time_nonzero;

  assign key_press    = key_valid & ~key_q_reg;
  assign start_edge   = start & ~start_q_reg;
  assign digit_ok     = (digit <= 4'd9);
  assign entry_room   = (count_reg < 3'(DIGITS));
  assign time_nonzero = (time_reg != '0);

  // ---------------------------------------------------------------------------
  // One-second BCD decrement of time_reg.
  //
  // Seconds non-zero: a normal borrow chain starting at the seconds ones digit.
  // Because the seconds field is non-zero the borrow never leaves it, so an
  // entered value such as 90 simply counts down as 89, 88, ...
  //
  // Seconds zero: the borrow chain starts at the minutes ones digit and the
  // seconds field is reloaded with SEC_WRAP.
  //
  // Each digit's borrow-in is derived from "all lower digits in the chain are
  // zero" rather than from the neighbouring digit's borrow-out, which keeps the
  // logic free of a digit-to-digit combinational chain.
  // ---------------------------------------------------------------------------
  logic [DIGITS-1:0] dig_zero;
  logic [W-1:0]      dec_bcd;
  logic              sec_nz;
  logic              dec_zero;

  assign sec_nz   = ~(dig_zero[0] & dig_zero[1]);
  assign dec_zero = (dec_bcd == '0);

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_dig
      logic [3:0] cur;
      logic [3:0] minus1;
      logic       b_in;

      assign cur          = time_reg[4*gi +: 4];
      assign dig_zero[gi] = (cur == 4'd0);
      assign minus1       = dig_zero[gi] ? 4'd9 : (cur - 4'd1);

      if (gi == 0) begin : g_b0
        assign b_in = sec_nz;
      end else if (gi == 1) begin : g_b1
        assign b_in = sec_nz & dig_zero[0];
      end else if (gi == 2) begin : g_b2
        assign b_in = ~sec_nz;
      end else begin : g_bn
        assign b_in = ~sec_nz & (&dig_zero[gi-1:2]);
      end

      if (gi < 2) begin : g_sec
        assign dec_bcd[4*gi +: 4] = sec_nz ? (b_in ? minus1 : cur)
                                           : WRAP_BCD[4*gi +: 4];
      end else begin : g_min
        assign dec_bcd[4*gi +: 4] = b_in ? minus1 : cur;
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Control: clear > start edge > key press > tick.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      time_reg    <= '0;
      count_reg   <= '0;
      running_reg <= 1'b0;
      done_reg    <= 1'b0;
      key_q_reg   <= 1'b0;
      start_q_reg <= 1'b0;
    end else begin
      key_q_reg   <= key_valid;
      start_q_reg <= start;

      if (clear) begin
        // Any press or tick arriving alongside clear is discarded.
        state_reg   <= ST_IDLE;
        time_reg    <= '0;
        count_reg   <= '0;
        running_reg <= 1'b0;
        done_reg    <= 1'b0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (start_edge) begin
              // A start edge owns the cycle; with no time entered it does nothing.
              if (time_nonzero) begin
                state_reg   <= ST_RUN;
                running_reg <= 1'b1;
              end
            end else if (key_press && digit_ok && entry_room) begin
              time_reg  <= {time_reg[W-5:0], digit};
              count_reg <= count_reg + 3'd1;
            end
          end

          ST_RUN: begin
            // A tick coinciding with a start edge is still applied.
            if (tick) begin
              time_reg <= dec_bcd;
            end
            if (tick && dec_zero) begin
              state_reg   <= ST_DONE;
              running_reg <= 1'b0;
              done_reg    <= 1'b1;
            end
`ifdef PAUSE_EN
            else if (start_edge) begin
              state_reg   <= ST_PAUSED;
              running_reg <= 1'b0;
            end
`endif
          end

`ifdef PAUSE_EN
          ST_PAUSED: begin
            // Time is frozen; only a start edge (or clear/reset) leaves.
            if (start_edge) begin
              state_reg   <= ST_RUN;
              running_reg <= 1'b1;
            end
          end
`endif

          ST_DONE: begin
            // Held until clear or reset.
            done_reg <= 1'b1;
          end

          default: begin
            state_reg   <= ST_IDLE;
            running_reg <= 1'b0;
            done_reg    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign time_bcd    = time_reg;
  assign entry_count = count_reg;
  assign running     = running_reg;
  assign done        = done_reg;

endmodule

// File: tb/tb_time_entry.sv
// -----------------------------------------------------------------------------
// tb_time_entry
//
// Directed steps followed by a randomized phase. A reference model holds the
// cook time as a plain decimal integer and derives the expected BCD outputs
// from it; every stimulus cycle compares all DUT outputs against the model.
// -----------------------------------------------------------------------------
module tb_time_entry;

  localparam int DIGITS   = 4;
  localparam int SEC_WRAP = 59;
  localparam int W        = 4 * DIGITS;

  localparam int M_IDLE   = 0;
  localparam int M_RUN    = 1;
  localparam int M_DONE   = 2;
  localparam int M_PAUSED = 3;

  logic         clk;
  logic         rst_n;
  logic [3:0]   digit;
  logic         key_valid;
  logic         clear;
  logic         start;
  logic         tick;
  logic [W-1:0] time_bcd;
  logic [2:0]   entry_count;
  logic         running;
  logic         done;

  int checks;
  int errors;

  // Reference model state
  int m_val;      // displayed time as a decimal number, e.g. 130 for 01:30
  int m_cnt;
  int m_state;
  bit m_kq;
  bit m_sq;

  time_entry #(
    .DIGITS   (DIGITS),
    .SEC_WRAP (SEC_WRAP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .digit       (digit),
    .key_valid   (key_valid),
    .clear       (clear),
    .start       (start),
    .tick        (tick),
    .time_bcd    (time_bcd),
    .entry_count (entry_count),
    .running     (running),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pow10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // One second off MM:SS; seconds are taken as entered (may exceed 59).
  function automatic int minus_one_second(input int v);
    int secs;
    int mins;
    secs = v % 100;
    mins = v / 100;
    if (secs > 0) return v - 1;
    return (mins - 1) * 100 + SEC_WRAP;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("time_bcd",    32'(time_bcd),    32'(to_bcd(m_val)));
    chk("entry_count", 32'(entry_count), 32'(m_cnt));
    chk("running",     32'(running),     32'(m_state == M_RUN));
    chk("done",        32'(done),        32'(m_state == M_DONE));
  endtask

  task automatic model_reset();
    m_val = 0; m_cnt = 0; m_state = M_IDLE; m_kq = 0; m_sq = 0;
  endtask

  // Drive one cycle of stimulus, advance the model, compare after the edge.
  task automatic step(input bit k, input logic [3:0] d, input bit c, input bit s, input bit t);
    bit press;
    bit sedge;
    key_valid = k; digit = d; clear = c; start = s; tick = t;
    press = k & ~m_kq;
    sedge = s & ~m_sq;
    m_kq  = k;
    m_sq  = s;
    if (c) begin
      m_val = 0; m_cnt = 0; m_state = M_IDLE;
    end else begin
      case (m_state)
        M_IDLE: begin
          if (sedge) begin
            if (m_val != 0) m_state = M_RUN;
          end else if (press && d <= 9 && m_cnt < DIGITS) begin
            m_val = (m_val * 10 + int'(d)) % pow10(DIGITS);
            m_cnt++;
          end
        end
        M_RUN: begin
          if (t) begin
            m_val = minus_one_second(m_val);
            if (m_val == 0) m_state = M_DONE;
          end
`ifdef PAUSE_EN
          if (m_state == M_RUN && sedge) m_state = M_PAUSED;
`endif
        end
        M_PAUSED: begin
          if (sedge) m_state = M_RUN;
        end
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic press_key(input logic [3:0] d);
    repeat (3) step(1, d, 0, 0, 0);
    step(0, d, 0, 0, 0);
  endtask

  task automatic pulse_start();
    step(0, 4'd0, 0, 1, 0);
    step(0, 4'd0, 0, 0, 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step(0, 4'd0, 0, 0, 1);
      step(0, 4'd0, 0, 0, 0);
    end
  endtask

  task automatic do_clear();
    step(0, 4'd0, 1, 0, 0);
    step(0, 4'd0, 0, 0, 0);
  endtask

  initial begin
    bit k;
    bit s;
    checks = 0;
    errors = 0;
    model_reset();
    rst_n = 1'b0; digit = 4'd0; key_valid = 1'b0; clear = 1'b0; start = 1'b0; tick = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_time",  32'(time_bcd),    32'h0);
    chk("reset_count", 32'(entry_count), 32'h0);
    chk("reset_run",   32'(running),     32'h0);
    chk("reset_done",  32'(done),        32'h0);
    rst_n = 1'b1;
    $display("txn reset released");

    // 1: keys 1,3,0 held three cycles each
    press_key(4'd1); press_key(4'd3); press_key(4'd0);
    chk("t1_time",  32'(time_bcd),    32'h0130);
    chk("t1_count", 32'(entry_count), 32'd3);
    $display("txn t1 time=%h count=%0d", time_bcd, entry_count);

    // 2: five digits, fifth ignored; invalid digit ignored; then clear
    do_clear();
    for (int i = 1; i <= 5; i++) press_key(4'(i));
    press_key(4'd11);
    chk("t2_time",  32'(time_bcd),    32'h1234);
    chk("t2_count", 32'(entry_count), 32'd4);
    do_clear();
    chk("t2_clear_time",  32'(time_bcd),    32'h0);
    chk("t2_clear_count", 32'(entry_count), 32'd0);
    $display("txn t2 time=%h count=%0d", time_bcd, entry_count);

    // 3: 01:00 countdown to done, further ticks inert
    press_key(4'd1); press_key(4'd0); press_key(4'd0);
    pulse_start();
    ticks(1);
    chk("t3_first",   32'(time_bcd), 32'h0059);
    chk("t3_running", 32'(running),  32'd1);
    ticks(59);
    chk("t3_zero",    32'(time_bcd), 32'h0);
    chk("t3_done",    32'(done),     32'd1);
    chk("t3_stopped", 32'(running),  32'd0);
    ticks(3);
    pulse_start();
    press_key(4'd5);
    chk("t3_hold_time", 32'(time_bcd), 32'h0);
    chk("t3_hold_done", 32'(done),     32'd1);
    $display("txn t3 time=%h done=%0d", time_bcd, done);

    // 4: start with zero time ignored; 90 counts down as-is
    do_clear();
    pulse_start();
    chk("t4_idle_run", 32'(running), 32'd0);
    press_key(4'd9); press_key(4'd0);
    pulse_start();
    ticks(1);
    chk("t4_time", 32'(time_bcd), 32'h0089);
    $display("txn t4 time=%h", time_bcd);

    // 5: press coincident with clear; async reset mid-run
    do_clear();
    press_key(4'd4); press_key(4'd5);
    pulse_start();
    chk("t5_run", 32'(running), 32'd1);
    step(1, 4'd7, 1, 0, 0);
    step(0, 4'd7, 0, 0, 0);
    chk("t5_clear_time",  32'(time_bcd),    32'h0);
    chk("t5_clear_count", 32'(entry_count), 32'd0);
    chk("t5_clear_run",   32'(running),     32'd0);
    press_key(4'd3); press_key(4'd0);
    pulse_start();
    ticks(2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_time",  32'(time_bcd),    32'h0);
    chk("t5_rst_count", 32'(entry_count), 32'h0);
    chk("t5_rst_run",   32'(running),     32'h0);
    chk("t5_rst_done",  32'(done),        32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    $display("txn t5 async reset time=%h", time_bcd);

    // 6: start edge while running (pause or ignored)
    press_key(4'd2); press_key(4'd0);
    pulse_start();
    pulse_start();
    ticks(5);
`ifdef PAUSE_EN
    chk("t6_paused_time", 32'(time_bcd), 32'h0020);
    chk("t6_paused_run",  32'(running),  32'd0);
`else
    chk("t6_run_time", 32'(time_bcd), 32'h0015);
    chk("t6_run_run",  32'(running),  32'd1);
`endif
    pulse_start();
    ticks(1);
`ifdef PAUSE_EN
    chk("t6_resumed", 32'(time_bcd), 32'h0019);
`else
    chk("t6_after",   32'(time_bcd), 32'h0014);
`endif
    $display("txn t6 time=%h running=%0d", time_bcd, running);

    // Randomized phase
    do_clear();
    k = 0;
    s = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) k = ~k;
      if ($urandom_range(0, 11) == 0) s = ~s;
      step(k, 4'($urandom_range(0, 11)), ($urandom_range(0, 79) == 0),
           s, ($urandom_range(0, 3) == 0));
      if (i % 250 == 0)
        $display("txn rand %0d time=%h count=%0d run=%0d done=%0d",
                 i, time_bcd, entry_count, running, done);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
